// File: rtl/param_dcache.sv
// param_dcache: parametrised two-way set-associative write-back data cache with burst fill/write-back and halt flush.
// Define PARAM_DCACHE_HITCNT_EN to count first-lookup hits and store the count to HIT_ADDR after the flush.
module param_dcache #(
    parameter int          SETS        = 8,
    parameter int          BLOCK_WORDS = 2,
    parameter logic [31:0] HIT_ADDR    = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int WOFF = $clog2(BLOCK_WORDS);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - WOFF - IDX;
    localparam int FW   = IDX + 1;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FSCAN,
        FWB,
`ifdef PARAM_DCACHE_HITCNT_EN
        CNT,
`endif
        DONE
    } state_t;

    state_t          state;
    logic [31:0]     maddr;
    logic            vway;
    logic [WOFF-1:0] wcnt;
    logic [FW-1:0]   fcnt;
    logic            post_fill;

    logic            valid    [2][SETS];
    logic            dirty    [2][SETS];
    logic            mru      [SETS];
    logic [TAGW-1:0] tag_mem  [2][SETS];
    logic [31:0]     data_mem [2][SETS][BLOCK_WORDS];

    logic [TAGW-1:0] req_tag, m_tag;
    logic [IDX-1:0]  req_idx, m_idx, fr_set;
    logic [WOFF-1:0] req_woff;
    logic            fr_way;
    logic            req, hit0, hit1, lookup_hit, hit_way, victim;
    logic            last_word, last_frame;
    logic            unused_bits;

    assign req_tag  = dmemaddr[31:32-TAGW];
    assign req_idx  = dmemaddr[2+WOFF +: IDX];
    assign req_woff = dmemaddr[2 +: WOFF];
    assign m_tag    = maddr[31:32-TAGW];
    assign m_idx    = maddr[2+WOFF +: IDX];
    assign fr_way   = fcnt[0];
    assign fr_set   = fcnt[FW-1:1];

    assign unused_bits = ^{dmemaddr[1:0], maddr[WOFF+1:0], HIT_ADDR};

    assign req        = dmemREN | dmemWEN;
    assign hit0       = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    assign hit1       = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    assign lookup_hit = hit0 | hit1;
    assign hit_way    = hit1;
    // Empty ways are filled before anything is evicted; otherwise the least recently used way goes.
    assign victim     = !valid[0][req_idx] ? 1'b0 :
                        !valid[1][req_idx] ? 1'b1 : ~mru[req_idx];
    assign last_word  = (wcnt == WOFF'(BLOCK_WORDS - 1));
    assign last_frame = (fcnt == {FW{1'b1}});

    assign dhit     = (state == IDLE) && !halt && req && lookup_hit;
    assign dmemload = dhit ? data_mem[hit_way][req_idx][req_woff] : 32'd0;

`ifdef PARAM_DCACHE_HITCNT_EN
    logic [31:0] hit_cnt;

    // The hit that completes a freshly filled miss is not a first-lookup hit, so post_fill masks it.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            hit_cnt <= 32'd0;
        end else if (dhit && !post_fill) begin
            hit_cnt <= hit_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = 32'd0;
        dstore  = 32'd0;
        flushed = 1'b0;
        case (state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_mem[vway][m_idx], m_idx, wcnt, 2'b00};
                dstore = data_mem[vway][m_idx][wcnt];
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {m_tag, m_idx, wcnt, 2'b00};
            end
            FWB: begin
                dWEN   = 1'b1;
                daddr  = {tag_mem[fr_way][fr_set], fr_set, wcnt, 2'b00};
                dstore = data_mem[fr_way][fr_set][wcnt];
            end
`ifdef PARAM_DCACHE_HITCNT_EN
            CNT: begin
                dWEN   = 1'b1;
                daddr  = {HIT_ADDR[31:2], 2'b00};
                dstore = hit_cnt;
            end
`endif
            DONE: flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (dhit && dmemWEN) begin
            data_mem[hit_way][req_idx][req_woff] <= dmemstore;
        end
        if (state == FILL && !dwait) begin
            data_mem[vway][m_idx][wcnt] <= dload;
            if (last_word) begin
                tag_mem[vway][m_idx] <= m_tag;
            end
        end
    end

    // After the last frame's write-back the counter stays put, so FSCAN revisits it clean and finishes.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            maddr     <= 32'd0;
            vway      <= 1'b0;
            wcnt      <= '0;
            fcnt      <= '0;
            post_fill <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid[0][s] <= 1'b0;
                valid[1][s] <= 1'b0;
                dirty[0][s] <= 1'b0;
                dirty[1][s] <= 1'b0;
                mru[s]      <= 1'b0;
            end
        end else begin
            post_fill <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        fcnt  <= '0;
                        state <= FSCAN;
                    end else if (dhit) begin
                        mru[req_idx] <= hit_way;
                        if (dmemWEN) begin
                            dirty[hit_way][req_idx] <= 1'b1;
                        end
                    end else if (req) begin
                        maddr <= dmemaddr;
                        vway  <= victim;
                        wcnt  <= '0;
                        state <= (valid[victim][req_idx] && dirty[victim][req_idx]) ? WB : FILL;
                    end
                end
                WB: begin
                    if (!dwait) begin
                        if (last_word) begin
                            wcnt  <= '0;
                            state <= FILL;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        if (last_word) begin
                            valid[vway][m_idx] <= 1'b1;
                            dirty[vway][m_idx] <= 1'b0;
                            wcnt      <= '0;
                            post_fill <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                FSCAN: begin
                    if (dirty[fr_way][fr_set]) begin
                        wcnt  <= '0;
                        state <= FWB;
                    end else if (last_frame) begin
`ifdef PARAM_DCACHE_HITCNT_EN
                        state <= CNT;
`else
                        state <= DONE;
`endif
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                FWB: begin
                    if (!dwait) begin
                        if (last_word) begin
                            dirty[fr_way][fr_set] <= 1'b0;
                            valid[fr_way][fr_set] <= 1'b0;
                            wcnt <= '0;
                            if (!last_frame) begin
                                fcnt <= fcnt + 1'b1;
                            end
                            state <= FSCAN;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
`ifdef PARAM_DCACHE_HITCNT_EN
                CNT: begin
                    if (!dwait) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_dcache.sv
// tb_param_dcache: randomized and directed checks of param_dcache against a transaction-level cache/memory model.
// Honours PARAM_DCACHE_HITCNT_EN the same way as the design.
module tb_param_dcache;
    localparam int          SETS     = 8;
    localparam int          BW       = 2;
    localparam logic [31:0] HIT_ADDR = 32'h0000_3100;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
    logic [31:0] dmemaddr = 32'd0, dmemstore = 32'd0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic [31:0] dload = 32'd0;
    logic        dwait = 1'b0;

    param_dcache #(.SETS(SETS), .BLOCK_WORDS(BW), .HIT_ADDR(HIT_ADDR)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] data;
    } op_t;

    op_t       exp_ops[$];
    op_t       acc_log[$];
    bit [31:0] mem [bit [31:0]];
    int        n_checks = 0;
    int        n_errors = 0;
    int        wait_mode = 0;
    int        stall_cnt = 0;

    bit        m_valid [2][SETS];
    bit        m_dirty [2][SETS];
    bit [31:0] m_tag   [2][SETS];
    bit [31:0] m_data  [2][SETS][BW];
    bit        m_mru   [SETS];
    int        m_hits;

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit [31:0] blk_addr(input bit [31:0] tag, input int idx, input int k);
        return ((tag * SETS + idx) * BW + k) * 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int v = 0; v < 2; v++) begin
                m_valid[v][s] = 0;
                m_dirty[v][s] = 0;
            end
            m_mru[s] = 0;
        end
        m_hits = 0;
    endtask

    // Abstract cache: lookup, victim choice, expected bus traffic and returned data for one request.
    task automatic model_access(input bit wr, input bit [31:0] a, input bit [31:0] wd,
                                output bit [31:0] rd, output bit hit, output bit wb);
        int idx, w, way, v;
        bit [31:0] tag;
        idx = int'((a / (4 * BW)) % SETS);
        tag = a / (4 * BW * SETS);
        w   = int'((a / 4) % BW);
        way = -1;
        wb  = 0;
        for (int i = 0; i < 2; i++)
            if (m_valid[i][idx] && m_tag[i][idx] == tag) way = i;
        hit = (way >= 0);
        if (hit) begin
            m_hits++;
            v = way;
        end else begin
            v  = !m_valid[0][idx] ? 0 : !m_valid[1][idx] ? 1 : (m_mru[idx] ? 0 : 1);
            wb = m_valid[v][idx] && m_dirty[v][idx];
            if (wb) begin
                for (int k = 0; k < BW; k++) begin
                    exp_ops.push_back('{1'b1, blk_addr(m_tag[v][idx], idx, k), m_data[v][idx][k]});
                    mem[blk_addr(m_tag[v][idx], idx, k)] = m_data[v][idx][k];
                end
            end
            for (int k = 0; k < BW; k++) begin
                exp_ops.push_back('{1'b0, blk_addr(tag, idx, k), 32'd0});
                m_data[v][idx][k] = mem_rd(blk_addr(tag, idx, k));
            end
            m_valid[v][idx] = 1;
            m_dirty[v][idx] = 0;
            m_tag[v][idx]   = tag;
        end
        if (wr) begin
            m_data[v][idx][w] = wd;
            m_dirty[v][idx]   = 1;
        end
        rd = m_data[v][idx][w];
        m_mru[idx] = (v == 1);
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int v = 0; v < 2; v++)
                if (m_valid[v][s] && m_dirty[v][s]) begin
                    for (int k = 0; k < BW; k++) begin
                        exp_ops.push_back('{1'b1, blk_addr(m_tag[v][s], s, k), m_data[v][s][k]});
                        mem[blk_addr(m_tag[v][s], s, k)] = m_data[v][s][k];
                    end
                    m_valid[v][s] = 0;
                    m_dirty[v][s] = 0;
                end
`ifdef PARAM_DCACHE_HITCNT_EN
        exp_ops.push_back('{1'b1, HIT_ADDR, 32'(m_hits)});
`endif
    endtask

    // Memory side: per-cycle bus comparison against the expected op queue, plus the dwait/dload responder.
    always @(negedge CLK) begin
        if (nRST) begin
            n_checks++;
            if (dREN && dWEN) begin
                n_errors++;
                $display("[TB] FAIL bus_excl: dREN %b dWEN %b both high", dREN, dWEN);
            end
            if (dREN || dWEN) begin
                n_checks++;
                if (exp_ops.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL bus_op: unexpected we=%b addr %h", dWEN, daddr);
                end else if (exp_ops[0].we != dWEN || exp_ops[0].addr != daddr ||
                             (exp_ops[0].we && exp_ops[0].data != dstore)) begin
                    n_errors++;
                    $display("[TB] FAIL bus_op: got we=%b addr %h data %h want we=%b addr %h data %h",
                             dWEN, daddr, dstore, exp_ops[0].we, exp_ops[0].addr, exp_ops[0].data);
                end
            end
            case (wait_mode)
                1: dwait = ($urandom_range(0, 2) == 0);
                2: dwait = (dREN || dWEN) && (stall_cnt < 2);
                default: dwait = 1'b0;
            endcase
            stall_cnt = (dwait && (dREN || dWEN)) ? stall_cnt + 1 : 0;
            dload = mem_rd(daddr);
            if ((dREN || dWEN) && !dwait) begin
                acc_log.push_back('{dWEN, daddr, dstore});
                if (exp_ops.size() != 0) void'(exp_ops.pop_front());
            end
        end
    end

    task automatic applyReset();
        nRST = 1'b0;
        dmemREN = 0; dmemWEN = 0; halt = 0; dmemaddr = 0; dmemstore = 0;
        exp_ops.delete();
        acc_log.delete();
        mem.delete();
        model_reset();
        stall_cnt = 0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_dhit", dhit, 0);
        checkOutput("rst_dmemload", dmemload, 0);
        checkOutput("rst_flushed", flushed, 0);
        checkOutput("rst_dREN", dREN, 0);
        checkOutput("rst_dWEN", dWEN, 0);
        checkOutput("rst_daddr", daddr, 0);
        checkOutput("rst_dstore", dstore, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic applyStimulus(input bit wr, input bit [31:0] a, input bit [31:0] wd, output int lat);
        bit [31:0] exp_rd;
        bit        hit, wb;
        model_access(wr, a, wd, exp_rd, hit, wb);
        dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = wd;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!dhit && lat < 300);
        checkOutput("dhit", dhit, 1);
        if (!wr) checkOutput("dmemload", dmemload, exp_rd);
        checkOutput("ops_drained", exp_ops.size(), 0);
        if (hit) checkOutput("hit_lat", lat, 1);
        else if (wait_mode == 0) checkOutput("miss_lat", lat, wb ? 2 + 2 * BW : 2 + BW);
        @(posedge CLK);
        #1 dmemREN = 0; dmemWEN = 0;
    endtask

    task automatic doFlush(input int exp_lat);
        int n;
        model_flush();
        halt = 1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!flushed && n < 3000);
        checkOutput("flushed", flushed, 1);
        checkOutput("flush_drained", exp_ops.size(), 0);
        if (exp_lat > 0) checkOutput("flush_lat", n, exp_lat);
        @(posedge CLK);
        #1 halt = 0;
        repeat (4) begin
            @(negedge CLK);
            checkOutput("flushed_held", flushed, 1);
            checkOutput("flush_quiet", dREN | dWEN, 0);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic logCheck(input string name, input int i, input bit we, input bit [31:0] addr,
                            input bit chk_data, input bit [31:0] data);
        if (i >= acc_log.size()) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL %s: log entry %0d missing, log has %0d", name, i, acc_log.size());
        end else begin
            checkOutput({name, "_we"}, acc_log[i].we, we);
            checkOutput({name, "_addr"}, acc_log[i].addr, addr);
            if (chk_data) checkOutput({name, "_data"}, acc_log[i].data, data);
        end
    endtask

    initial begin
        int lat, n;
        bit [31:0] exp_rd;
        bit hit, wb;

        // Cold read miss then zero-latency neighbour hit
        applyReset();
        wait_mode = 0;
        applyStimulus(0, 32'h40, 0, lat);
        checkOutput("cold_lat", lat, 4);
        logCheck("cold0", 0, 0, 32'h40, 0, 0);
        logCheck("cold1", 1, 0, 32'h44, 0, 0);
        applyStimulus(0, 32'h44, 0, lat);
        checkOutput("neigh_lat", lat, 1);

        // Dirty eviction of the LRU way
        applyStimulus(1, 32'h40, 32'hDEAD, lat);
        applyStimulus(0, 32'h80, 0, lat);
        acc_log.delete();
        applyStimulus(0, 32'hC0, 0, lat);
        logCheck("evict0", 0, 1, 32'h40, 1, 32'hDEAD);
        logCheck("evict1", 1, 1, 32'h44, 0, 0);
        logCheck("evict2", 2, 0, 32'hC0, 0, 0);

        // Invalid-way preference then LRU victim
        applyReset();
        applyStimulus(0, 32'h40, 0, lat);
        applyStimulus(0, 32'h80, 0, lat);
        applyStimulus(0, 32'h40, 0, lat);
        applyStimulus(0, 32'hC0, 0, lat);
        applyStimulus(0, 32'h40, 0, lat);
        checkOutput("lru_keep_lat", lat, 1);
        applyStimulus(0, 32'h80, 0, lat);
        checkOutput("lru_evicted_lat", lat, 4);

        // Request dropped mid-fill with 3-cycle words
        applyReset();
        wait_mode = 2;
        model_access(0, 32'h100, 0, exp_rd, hit, wb);
        dmemREN = 1; dmemaddr = 32'h100;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 dmemREN = 0;
        n = 0;
        while (exp_ops.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
            checkOutput("drop_no_dhit", dhit, 0);
        end
        checkOutput("drop_drained", exp_ops.size(), 0);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("drop_idle_no_dhit", dhit, 0);
        end
        logCheck("drop0", 0, 0, 32'h100, 0, 0);
        logCheck("drop1", 1, 0, 32'h104, 0, 0);
        @(posedge CLK);
        #1;
        applyStimulus(0, 32'h100, 0, lat);
        checkOutput("drop_rehit_lat", lat, 1);

        // Reset mid-burst drops strobes and forgets contents
        applyReset();
        wait_mode = 0;
        applyStimulus(0, 32'h40, 0, lat);
        wait_mode = 2;
        model_access(0, 32'h200, 0, exp_rd, hit, wb);
        dmemREN = 1; dmemaddr = 32'h200;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 nRST = 0;
        #1;
        checkOutput("async_dREN", dREN, 0);
        checkOutput("async_dWEN", dWEN, 0);
        checkOutput("async_daddr", daddr, 0);
        applyReset();
        wait_mode = 0;
        applyStimulus(0, 32'h40, 0, lat);
        checkOutput("lost_lat", lat, 4);

        // Flush with two dirty frames after five first-lookup hits
        applyReset();
        applyStimulus(0, 32'h40, 0, lat);
        applyStimulus(1, 32'h40, 32'h1111, lat);
        applyStimulus(1, 32'h44, 32'h2222, lat);
        applyStimulus(0, 32'h44, 0, lat);
        applyStimulus(0, 32'h80, 0, lat);
        applyStimulus(1, 32'h80, 32'h3333, lat);
        applyStimulus(0, 32'h84, 0, lat);
        checkOutput("model_hits", m_hits, 5);
        acc_log.delete();
        doFlush(0);
        logCheck("fl0", 0, 1, 32'h40, 1, 32'h1111);
        logCheck("fl1", 1, 1, 32'h44, 1, 32'h2222);
        logCheck("fl2", 2, 1, 32'h80, 1, 32'h3333);
        logCheck("fl3", 3, 1, 32'h84, 0, 0);
`ifdef PARAM_DCACHE_HITCNT_EN
        logCheck("flcnt", 4, 1, HIT_ADDR, 1, 32'd5);
        checkOutput("fl_count", acc_log.size(), 5);
`else
        checkOutput("fl_count", acc_log.size(), 4);
`endif

        // Clean flush timing: one cycle per frame
        applyReset();
        applyStimulus(0, 32'h40, 0, lat);
`ifdef PARAM_DCACHE_HITCNT_EN
        doFlush(2 * SETS + 3);
`else
        doFlush(2 * SETS + 2);
`endif

        // Randomized traffic with random memory stalls, then flush
        applyReset();
        wait_mode = 1;
        for (int i = 0; i < 250; i++) begin
            bit [31:0] a;
            a = blk_addr($urandom_range(0, 3), int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, BW - 1)));
            applyStimulus($urandom_range(0, 9) < 4, a, $urandom, lat);
        end
        doFlush(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/param_dcache.md
# param_dcache

Parametrised two-way set-associative write-back data cache sitting between the datapath `dcache` modport and the memory-side `caches_if.dcache` modport. Next generation of the fixed 8-set, 2-word data cache: set count and block size are generic, fills and write-backs use word-burst counters, misses latch the request address, and an invalid way is preferred over the LRU victim. On `halt` it flushes every dirty frame, optionally stores a hit count, then asserts `flushed`.

## Interface
- `SETS`, 8: number of sets. Power of two, ≥2.
- `BLOCK_WORDS`, 2: 32-bit words per block. Power of two, ≥2.
- `HIT_ADDR`, 32'h0000_3100: word address that receives the hit count at the end of the flush.
- `CLK`, in, 1: clock, rising edge.
- `nRST`, in, 1: asynchronous, active-low reset.
- `dmemREN`, in, 1: datapath load request.
- `dmemWEN`, in, 1: datapath store request.
- `dmemaddr`, in, 32: byte address.
- `dmemstore`, in, 32: store data.
- `halt`, in, 1: request to flush the cache.
- `dhit`, out, 1: request served this cycle.
- `dmemload`, out, 32: load data, valid when `dhit` is high.
- `flushed`, out, 1: flush and count store are complete.
- `dREN`, out, 1: memory read strobe.
- `dWEN`, out, 1: memory write strobe.
- `daddr`, out, 32: memory word address, bits [1:0] always 0.
- `dstore`, out, 32: memory write data.
- `dload`, in, 32: memory read data.
- `dwait`, in, 1: memory busy. The current word is accepted in any cycle where `dwait` is 0.

## Operation
- **Address split**: [1:0] byte offset (ignored), then WOFF = log2(BLOCK_WORDS) word-offset bits, then IDX = log2(SETS) index bits. The tag is the remaining 32−2−WOFF−IDX bits.
- **Per-set state**: two frames, each holding valid, dirty, tag and BLOCK_WORDS data words, plus one MRU bit per set.
- **Hit**: the tag matches in a valid way while REN or WEN is high. Reads return the addressed word. Writes update the addressed word and set dirty. Both set MRU to the hit way.
- **Victim selection**: an invalid way is chosen first, way 0 before way 1. Otherwise the victim is the way that is not MRU.
- **FSM states**:
  - IDLE: `halt` has priority and goes to FSCAN. A miss latches the address into `maddr`, then goes to WB if the victim is dirty, else FILL.
  - WB: write the victim block, one word per accept. The word counter `wcnt` runs 0..BLOCK_WORDS−1. Address is {victim tag, idx, wcnt, 2'b00}. After the last word goes to FILL with `wcnt` cleared.
  - FILL: read {maddr tag, idx, wcnt, 2'b00}. Each accepted word is written into the victim frame. On the last word: valid=1, dirty=0, tag installed, MRU unchanged, then go to IDLE.
  - FSCAN: the frame counter `fcnt` (log2(SETS)+1 bits) visits set 0 way 0, set 0 way 1, set 1 way 0, and so on. A dirty frame goes to FWB. A clean frame advances `fcnt`. After the last frame goes to CNT (or DONE if the macro is off).
  - FWB: burst-write the frame as in WB. After the last word, clear dirty and valid, advance `fcnt`, and return to FSCAN.
  - CNT: hold `dWEN`, `daddr`=HIT_ADDR, `dstore`=hit count until accepted, then go to DONE.
  - DONE: `flushed`=1. Held until reset.
- **Request dropped mid-miss**: the burst still completes using `maddr`. No `dhit` is issued outside IDLE.
- **`halt` during WB/FILL**: ignored until back in IDLE, so the in-flight miss always finishes first.
- **Mutual exclusion**: `dREN` and `dWEN` are never high together. Both are 0 in IDLE, FSCAN and DONE.

## Timing
- **Reset values**: all outputs 0. State IDLE. All valid, dirty and MRU bits 0. Counters 0.
- **Hit path**: zero latency, combinational `dhit`/`dmemload` in the same cycle. Store data and MRU commit at the next edge.
- **Miss latency**: 1 cycle IDLE→WB/FILL. Each word takes ≥1 cycle and advances exactly on `dwait`=0. The filled block hits on the first IDLE cycle after the last FILL accept.
- **Minimum miss cost, clean victim, `dwait` low**: 1 + BLOCK_WORDS cycles before the hit.
- **FSCAN**: one cycle per clean frame.
- **Reset mid-burst**: strobes drop asynchronously and all cached contents are lost, with no write-back.

## Configuration
- `PARAM_DCACHE_HITCNT_EN` defined:
  - A 32-bit hit counter increments on every IDLE cycle with a first-lookup hit.
  - It does not increment on the post-fill hit of a missed request.
  - It wraps modulo 2^32.
  - The CNT state runs after the flush.
- Undefined: no counter and no CNT state. FSCAN goes directly to DONE, and no write to HIT_ADDR is ever issued.

## Test plan
- **Cold read miss**: read 0x40 with SETS=8, BLOCK_WORDS=2, `dwait` low → `dREN` at 0x40 then 0x44, then `dhit` with `dload` word 0. A read of 0x44 then hits with zero latency.
- **Dirty eviction**: write 0xDEAD to 0x40, fill 0x80 and 0xC0 (same set) → `dWEN` to 0x40=0xDEAD and 0x44 before the `dREN` of 0xC0.
- **Invalid-way preference and LRU**: after filling way 0, a second tag lands in way 1. Hit way 0, then miss with a third tag → way 1 is evicted.
- **Request dropped mid-FILL with `dwait` stretched to 3 cycles**: the burst completes at the latched address. No `dhit` until REN is reasserted.
- **Halt flush with 2 dirty frames, macro on, 5 prior hits**: exactly 4 write-back `dWEN` words in frame order, then the HIT_ADDR write with 5, then `flushed`=1 held.
- **Halt flush with the macro off**: no HIT_ADDR write, and `flushed` rises the cycle after the final FSCAN.
